prbs7_checker: RTL

Serial PRBS7 receiver/checker for the x^7 + x^6 + 1 sequence produced by the team's 7-bit LFSR generator.

- Takes one bit per enabled cycle and self-synchronises by seeding from the received stream.
- Once synchronised, compares each incoming bit against a free-running local copy of the sequence, flags mismatches and counts them.
- Sits at the far end of a link or loopback, opposite the LFSR generator.

---
 rtl/prbs_pkg.sv | 19 +
 rtl/sat_counter.sv | 34 +++
 rtl/prbs7_checker.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared types, constants and next-bit function for the PRBS7 (x^7 + x^6 + 1) checker.
package prbs_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam int PRBS7_W     = 7;
    localparam int PRBS7_TAP_A = 6;
    localparam int PRBS7_TAP_B = 5;

    // History holds the newest bit in [0]; the next bit is the XOR of the two oldest taps.
    function automatic logic prbs7_next(input logic [PRBS7_W-1:0] h);
        return h[PRBS7_TAP_A] ^ h[PRBS7_TAP_B];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = '0;
        end else if (inc && (q_reg != '1)) begin
            q_next = q_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/prbs7_checker.sv
// Self-synchronising serial PRBS7 checker with saturating error counter.
// Optional bit counter for BER measurement enabled by macro PRBS7_CHK_BITCNT_EN.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
`ifdef PRBS7_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_THRESH - 1);

    chk_state_t           state_reg, state_next;
    logic [PRBS7_W-1:0]   h_reg, h_next;
    logic [2:0]           fill_reg, fill_next;
    logic [7:0]           match_reg, match_next;
    logic [3:0]           loss_reg, loss_next;
    logic                 locked_reg, locked_next;
    logic                 err_reg, err_next;
    logic                 exp_bit;
    logic                 mismatch;
    logic                 err_inc;
    logic [PRBS7_W-1:0]   h_din;
    logic [PRBS7_W-1:0]   h_fb;

    assign exp_bit  = prbs7_next(h_reg);
    assign mismatch = (din != exp_bit);

    // Two candidate shifts: from the line while acquiring, from own feedback once locked.
    assign h_din[0] = din;
    assign h_fb[0]  = exp_bit;
    generate
        for (genvar gi = 1; gi < PRBS7_W; gi++) begin : g_shift
            assign h_din[gi] = h_reg[gi-1];
            assign h_fb[gi]  = h_reg[gi-1];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        h_next     = h_reg;
        fill_next  = fill_reg;
        match_next = match_reg;
        loss_next  = loss_reg;
        err_inc    = 1'b0;
        if (en) begin
            case (state_reg)
                FILL: begin
                    h_next = h_din;
                    if (fill_reg == 3'd6) begin
                        fill_next  = 3'd0;
                        state_next = SEARCH;
                    end else begin
                        fill_next = fill_reg + 3'd1;
                    end
                end
                SEARCH: begin
                    h_next = h_din;
                    // An all-zero history predicts zeros forever, so it never counts toward lock.
                    if (!mismatch && (h_reg != '0)) begin
                        if (match_reg == LOCK_LAST) begin
                            match_next = 8'd0;
                            state_next = LOCKED;
                        end else begin
                            match_next = match_reg + 8'd1;
                        end
                    end else begin
                        match_next = 8'd0;
                    end
                end
                LOCKED: begin
                    h_next = h_fb;
                    if (mismatch) begin
                        err_inc = 1'b1;
                        if (loss_reg == LOSS_LAST) begin
                            state_next = FILL;
                            h_next     = '0;
                            fill_next  = 3'd0;
                            match_next = 8'd0;
                            loss_next  = 4'd0;
                        end else begin
                            loss_next = loss_reg + 4'd1;
                        end
                    end else begin
                        loss_next = 4'd0;
                    end
                end
                default: begin
                    state_next = FILL;
                    h_next     = '0;
                    fill_next  = 3'd0;
                    match_next = 8'd0;
                    loss_next  = 4'd0;
                end
            endcase
        end
        locked_next = (state_next == LOCKED);
        err_next    = err_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= FILL;
            h_reg      <= '0;
            fill_reg   <= 3'd0;
            match_reg  <= 8'd0;
            loss_reg   <= 4'd0;
            locked_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            h_reg      <= h_next;
            fill_reg   <= fill_next;
            match_reg  <= match_next;
            loss_reg   <= loss_next;
            locked_reg <= locked_next;
            err_reg    <= err_next;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_inc),
        .clr  (clr),
        .q    (err_count)
    );

`ifdef PRBS7_CHK_BITCNT_EN
    logic [31:0] bit_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg <= 32'd0;
        end else if (clr) begin
            bit_cnt_reg <= 32'd0;
        end else if (en && (state_reg == LOCKED)) begin
            bit_cnt_reg <= bit_cnt_reg + 32'd1;
        end
    end

    assign bit_count = bit_cnt_reg;
`endif

    assign locked = locked_reg;
    assign err    = err_reg;

endmodule
